vga_text_writer: RTL and testbench

- Producer side of the VGA text-buffer write port: drives wen/w_addr/w_data into the 80x30 character buffer scanned by the text display.
- Accepts a byte stream over a valid/ready handshake, keeps a cursor, and handles control codes: newline, carriage return, backspace, form feed.
- Clears each new line on row advance; clears the whole screen on form feed.
- Sits between a CPU/UART console source and the text display.

---
 rtl/vga_text_writer.sv | 169 ++++++++++++++++
 tb/tb_vga_text_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_writer.sv
// vga_text_writer
//   Producer side of the 80x30 text-buffer write port. Takes a byte stream
//   over valid/ready, tracks a cursor and turns printable bytes and control
//   codes (LF, CR, BS, FF) into single-cell buffer writes. Advancing to a new
//   row blanks that row. Form feed blanks the whole screen.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     char_valid/char_data  byte stream in (source holds data until accepted)
//     char_ready            high only when idle and able to take a byte
//     wen/w_addr/w_data     buffer write port, one cell per cycle
//     cursor_x/cursor_y     current cursor column/row
//
//   Optional feature: define VGA_TEXT_WRITER_INIT_CLEAR_EN to blank the whole
//   buffer after every reset release before the first byte is accepted.
module vga_text_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 12,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        w_data,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y
);

    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;

    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] COLS_M1  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CELLS_M1 = ADDR_W'(ROWS * COLS - 1);
    localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);

`ifdef VGA_TEXT_WRITER_INIT_CLEAR_EN
    // Leaving reset straight into a full-screen clear.
    localparam state_t RST_STATE = CLR_ALL;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t            state_q;
    logic              ready_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [6:0]        col_q;
    logic [4:0]        row_q;
    logic [ADDR_W-1:0] row_base_q;  // row_q*COLS, kept incrementally
    logic [ADDR_W-1:0] clr_cnt_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] adv_base;
    logic [4:0]        adv_row;
    logic              accept;
    logic              printable;

    always_comb begin
        cur_addr  = row_base_q + ADDR_W'(col_q);
        adv_row   = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
        adv_base  = (row_q == ROW_LAST) ? '0 : row_base_q + COLS_A;
        accept    = char_valid && ready_q;
        printable = (char_data >= 8'h20) && (char_data <= 8'h7E);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            ready_q    <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            clr_cnt_q  <= '0;
        end else begin
            wen_q   <= 1'b0;
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Ready rises one cycle after any clear finishes.
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (printable) begin
                            wen_q  <= 1'b1;
                            addr_q <= cur_addr;
                            data_q <= char_data;
                            if (col_q != COL_LAST) begin
                                col_q <= col_q + 7'd1;
                            end else begin
                                // Wrap: clear of the new row follows the char write.
                                col_q      <= '0;
                                row_q      <= adv_row;
                                row_base_q <= adv_base;
                                clr_cnt_q  <= '0;
                                state_q    <= CLR_LINE;
                                ready_q    <= 1'b0;
                            end
                        end else begin
                            case (char_data)
                                8'h0A: begin
                                    // First blank of the new row goes out now.
                                    col_q      <= '0;
                                    row_q      <= adv_row;
                                    row_base_q <= adv_base;
                                    wen_q      <= 1'b1;
                                    addr_q     <= adv_base;
                                    data_q     <= BLANK;
                                    clr_cnt_q  <= ADDR_W'(1);
                                    state_q    <= CLR_LINE;
                                    ready_q    <= 1'b0;
                                end
                                8'h0D: col_q <= '0;
                                8'h08: begin
                                    if (col_q != 7'd0) begin
                                        col_q  <= col_q - 7'd1;
                                        wen_q  <= 1'b1;
                                        addr_q <= cur_addr - ADDR_W'(1);
                                        data_q <= BLANK;
                                    end
                                end
                                8'h0C: begin
                                    col_q      <= '0;
                                    row_q      <= '0;
                                    row_base_q <= '0;
                                    clr_cnt_q  <= '0;
                                    state_q    <= CLR_ALL;
                                    ready_q    <= 1'b0;
                                end
                                default: ;  // dropped
                            endcase
                        end
                    end
                end
                CLR_LINE: begin
                    wen_q     <= 1'b1;
                    addr_q    <= row_base_q + clr_cnt_q;
                    data_q    <= BLANK;
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == COLS_M1) state_q <= IDLE;
                end
                CLR_ALL: begin
                    wen_q     <= 1'b1;
                    addr_q    <= clr_cnt_q;
                    data_q    <= BLANK;
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == CELLS_M1) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign char_ready = ready_q;
    assign wen        = wen_q;
    assign w_addr     = addr_q;
    assign w_data     = data_q;
    assign cursor_x   = col_q;
    assign cursor_y   = row_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Bench for vga_text_writer: a queue-based model of pending buffer writes and
// the cursor, compared to the DUT every cycle, plus literal spot checks.
module tb_vga_text_writer;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk;
    logic        rst_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        wen;
    logic [11:0] w_addr;
    logic [7:0]  w_data;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    vga_text_writer dut (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .wen(wen), .w_addr(w_addr), .w_data(w_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wen_cnt = 0;

    typedef struct packed {
        logic        v;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t pend[$];
    int  mx, my;
    logic        e_wen, e_ready;
    logic [11:0] e_addr;
    logic [7:0]  e_data;
    logic        was_empty;
    wr_t         cur;

    function automatic wr_t mk(logic v, int a, logic [7:0] d);
        wr_t w;
        w.v = v; w.a = 12'(a); w.d = d;
        return w;
    endfunction

    task automatic push_row_clear(int row);
        for (int i = 0; i < COLS; i++) pend.push_back(mk(1'b1, row * COLS + i, 8'h20));
    endtask

    task automatic push_full_clear();
        for (int i = 0; i < ROWS * COLS; i++) pend.push_back(mk(1'b1, i, 8'h20));
    endtask

    // Effect of one accepted byte: writes it causes (in order) and cursor move.
    task automatic model_byte(logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            pend.push_back(mk(1'b1, my * COLS + mx, b));
            if (mx < COLS - 1) mx++;
            else begin
                mx = 0; my = (my + 1) % ROWS;
                push_row_clear(my);
            end
        end else if (b == 8'h0A) begin
            mx = 0; my = (my + 1) % ROWS;
            push_row_clear(my);
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                pend.push_back(mk(1'b1, my * COLS + mx, 8'h20));
            end
        end else if (b == 8'h0C) begin
            mx = 0; my = 0;
            pend.push_back(mk(1'b0, 0, 8'h00));  // one quiet cycle before the sweep
            push_full_clear();
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            mx = 0; my = 0;
            e_wen = 1'b0; e_ready = 1'b0; e_addr = '0; e_data = '0;
`ifdef VGA_TEXT_WRITER_INIT_CLEAR_EN
            push_full_clear();
`endif
        end else begin
            was_empty = (pend.size() == 0);
            if (char_valid && e_ready) model_byte(char_data);
            cur = '0;
            if (pend.size() > 0) cur = pend.pop_front();
            e_wen = cur.v;
            if (cur.v) begin
                e_addr = cur.a;
                e_data = cur.d;
            end
            e_ready = was_empty && (pend.size() == 0);
        end
        #1;
        if (wen === 1'b1) wen_cnt++;
        n_tests++;
        if (wen !== e_wen || char_ready !== e_ready || cursor_x !== 7'(mx) ||
            cursor_y !== 5'(my) || (e_wen && (w_addr !== e_addr || w_data !== e_data))) begin
            n_fail++;
            if (n_fail < 30)
                $display("FAIL cycle t=%0t: got wen=%b rdy=%b addr=%0d data=%h cur=(%0d,%0d) want wen=%b rdy=%b addr=%0d data=%h cur=(%0d,%0d)",
                         $time, wen, char_ready, w_addr, w_data, cursor_x, cursor_y,
                         e_wen, e_ready, e_addr, e_data, mx, my);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Offer a byte; returns #1 after the accepting edge.
    task automatic send(logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = b;
        while (char_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (char_ready !== 1'b1) begin
            chk("send_timeout", 32'(n), 32'd0);
            char_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (char_ready !== 1'b1) chk("ready_timeout", 32'(n), 32'd0);
    endtask

    int w0;
    int r;
    logic [7:0] rb;

    initial begin
        rst_n = 1'b0; char_valid = 1'b0; char_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_wen",   32'(wen), 32'd0);
        chk("rst_addr",  32'(w_addr), 32'd0);
        chk("rst_data",  32'(w_data), 32'd0);
        chk("rst_cx",    32'(cursor_x), 32'd0);
        chk("rst_cy",    32'(cursor_y), 32'd0);
        w0 = wen_cnt;
        rst_n = 1'b1;
`ifdef VGA_TEXT_WRITER_INIT_CLEAR_EN
        wait_ready();
        chk("init_clear_writes", 32'(wen_cnt - w0), 32'd2400);
`else
        @(posedge clk); #1;
        chk("ready_after_release", 32'(char_ready), 32'd1);
`endif

        // printable at origin
        send(8'h41);
        chk("A_wen",  32'(wen), 32'd1);
        chk("A_addr", 32'(w_addr), 32'd0);
        chk("A_data", 32'(w_data), 32'h41);
        chk("A_cx",   32'(cursor_x), 32'd1);
        chk("A_cy",   32'(cursor_y), 32'd0);

        // LF then B
        send(8'h0D);
        @(negedge clk);
        w0 = wen_cnt;
        send(8'h0A);
        chk("LF_first_addr", 32'(w_addr), 32'd80);
        chk("LF_first_ready", 32'(char_ready), 32'd0);
        wait_ready();
        chk("LF_clear_writes", 32'(wen_cnt - w0), 32'd80);
        send(8'h42);
        chk("B_addr", 32'(w_addr), 32'd80);
        chk("B_data", 32'(w_data), 32'h42);
        chk("B_cx",   32'(cursor_x), 32'd1);
        chk("B_cy",   32'(cursor_y), 32'd1);

        // last row wrap to row 0
        send(8'h0C);
        wait_ready();
        for (int i = 0; i < 29; i++) send(8'h0A);
        wait_ready();
        chk("row29_cy", 32'(cursor_y), 32'd29);
        for (int i = 0; i < 80; i++) send(8'h5A);
        chk("Z_last_addr", 32'(w_addr), 32'd2399);
        chk("Z_last_data", 32'(w_data), 32'h5A);
        wait_ready();
        chk("wrap_cx", 32'(cursor_x), 32'd0);
        chk("wrap_cy", 32'(cursor_y), 32'd0);

        // backspace at (3,2) and at col 0
        send(8'h0A); send(8'h0A);
        send(8'h61); send(8'h62); send(8'h63);
        send(8'h08);
        chk("BS_addr", 32'(w_addr), 32'd162);
        chk("BS_data", 32'(w_data), 32'h20);
        chk("BS_cx",   32'(cursor_x), 32'd2);
        send(8'h0D);
        send(8'h08);
        chk("BS0_wen", 32'(wen), 32'd0);
        chk("BS0_cx",  32'(cursor_x), 32'd0);
        chk("BS0_cy",  32'(cursor_y), 32'd2);

        // form feed full clear
        @(negedge clk);
        w0 = wen_cnt;
        send(8'h0C);
        wait_ready();
        chk("FF_writes", 32'(wen_cnt - w0), 32'd2400);
        chk("FF_cx", 32'(cursor_x), 32'd0);
        chk("FF_cy", 32'(cursor_y), 32'd0);

        // ignored bytes
        send(8'h33);
        send(8'h07);
        chk("BEL_wen", 32'(wen), 32'd0);
        chk("BEL_cx",  32'(cursor_x), 32'd1);
        chk("BEL_rdy", 32'(char_ready), 32'd1);
        send(8'h7F);
        chk("DEL_wen", 32'(wen), 32'd0);
        chk("DEL_cx",  32'(cursor_x), 32'd1);

        // reset in the middle of a full clear
        send(8'h0C);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_wen", 32'(wen), 32'd0);
        chk("midrst_cx",  32'(cursor_x), 32'd0);
        chk("midrst_cy",  32'(cursor_y), 32'd0);
        repeat (3) @(negedge clk);
        w0 = wen_cnt;
        rst_n = 1'b1;
`ifndef VGA_TEXT_WRITER_INIT_CLEAR_EN
        repeat (10) @(negedge clk);
        chk("midrst_no_writes", 32'(wen_cnt - w0), 32'd0);
`endif
        wait_ready();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      rb = 8'(32'h20 + $urandom_range(0, 94));
            else if (r < 70) rb = 8'h0A;
            else if (r < 76) rb = 8'h0D;
            else if (r < 88) rb = 8'h08;
            else if (r < 89) rb = 8'h0C;
            else             rb = 8'($urandom_range(0, 255));
            send(rb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_ready();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
